alarm_zone_ctrl: RTL and testbench
==================================

ALARM_ZONE_CTRL -- requirements
Module: alarm_zone_ctrl

Interface
REQ-001 SHALL have parameter N_ZONES, default 4, number of sensor zones (1..16).
REQ-002 SHALL have parameter DIGIT_W, default 2, keypad digit width.
REQ-003 SHALL have parameter CODE_LEN, default 4, digits per code entry.
REQ-004 SHALL have parameter CODE, default all-ones digits ({CODE_LEN{DIGIT_W'd1}}), packed code, first digit in MS position.
REQ-005 SHALL have parameter MAX_TRIES, default 3, consecutive wrong codes before alarm.
REQ-006 SHALL have parameter ENTRY_CYCLES, default 8, entry-delay length in clocks.
REQ-007 SHALL have port SERCLK_OUT  in  1  system clock, rising edge.
REQ-008 SHALL have port RESET_IN  in  1  reset, asynchronous, active-low.
REQ-009 SHALL have port SENSOR_IN  in  N_ZONES  zone sensors, 1 = tripped, synchronous to SERCLK_OUT.
REQ-010 SHALL have port KB_IN  in  DIGIT_W  keypad digit.
REQ-011 SHALL have port KB_RECV  in  1  digit strobe; digit taken on its 0->1 transition.
REQ-012 SHALL have port SIREN_OUT  out  1  siren drive.
REQ-013 SHALL have port STATUS_OUT  out  1  serial status data.
REQ-014 SHALL have port STATUS_SEND  out  1  high while a status bit is valid on STATUS_OUT.

Function
REQ-015 SHALL implement FSM DISARMED(00), ARMED(01), ENTRY(10), ALARM(11); all transitions take effect on the clock edge after the causing input is sampled.
REQ-016 SHALL register KB_RECV and capture KB_IN in the cycle the rising edge is detected; KB_RECV held high SHALL yield one digit only.
REQ-017 SHALL shift digits into a CODE_LEN-deep buffer; on the CODE_LEN-th digit compare against CODE, then clear the digit count.
REQ-018 Correct code: DISARMED->ARMED if SENSOR_IN==0, else stay DISARMED (arm refused); ARMED/ENTRY/ALARM->DISARMED; wrong-try counter cleared.
REQ-019 Wrong code: increment wrong-try counter; on reaching MAX_TRIES go to ALARM from any state and clear counter.
REQ-020 ARMED with any SENSOR_IN bit high: go to ENTRY (macro defined) or ALARM (macro undefined).
REQ-021 ENTRY: count ENTRY_CYCLES clocks, then ALARM unless a correct code completes first.
REQ-022 SIREN_OUT SHALL be a registered output, high exactly while state is ALARM.
REQ-023 Zone latch (N_ZONES bits) SHALL OR in SENSOR_IN while not DISARMED; cleared on entry to DISARMED.
REQ-024 On every state change, SHALL send a frame MSB-first, one bit per clock: start bit 1, 2-bit new state, zone latch bit N_ZONES-1..0; STATUS_SEND high for exactly 3+N_ZONES cycles.
REQ-025 State change during a frame SHALL set a pending flag; one new frame carrying the then-current state starts the cycle after the current frame ends; further changes merge into the same pending frame.
REQ-026 STATUS_OUT SHALL be 0 whenever STATUS_SEND is 0.
REQ-027 Code completion and sensor trip in the same cycle: code takes priority.
REQ-028 Digit entry SHALL be accepted in all states, including during frames.

Reset
REQ-029 RESET_IN low SHALL immediately force DISARMED, SIREN_OUT=0, STATUS_OUT=0, STATUS_SEND=0, clear digit buffer/count, wrong-try counter, entry counter, zone latch, pending flag; abort any frame.
REQ-030 After reset release, no frame SHALL be sent until the first state change.

Configuration
REQ-031 Macro ALARM_ENTRY_DELAY_EN defined: ENTRY state and entry counter present per REQ-020/021.
REQ-032 Macro ALARM_ENTRY_DELAY_EN undefined: ENTRY state and counter absent; trip in ARMED goes directly to ALARM; state code 10 never sent.

Verification (N_ZONES=4, CODE=digits 1,1,1,1, MAX_TRIES=3, ENTRY_CYCLES=8)
REQ-033 Reset, enter 1,1,1,1 with SENSOR_IN=0 -> ARMED; frame 1,0,1,0,0,0,0 with STATUS_SEND high 7 cycles.
REQ-034 ARMED, SENSOR_IN=4'b0010 one cycle (macro defined) -> ENTRY, then ALARM 8 cycles later, SIREN_OUT=1; frames show zone latch 0010.
REQ-035 In ENTRY enter 1,1,1,1 before timeout -> DISARMED, SIREN_OUT stays 0, latch cleared in frame 1,0,0,0,0,0,0.
REQ-036 DISARMED, three codes 0,0,0,0 -> ALARM after third; KB_RECV held high 5 cycles counts as one digit.
REQ-037 Arm attempt with SENSOR_IN=4'b0001 -> stays DISARMED, no frame sent.
REQ-038 Assert RESET_IN low mid-frame while in ALARM -> SIREN_OUT, STATUS_SEND, STATUS_OUT go 0 without waiting for a clock edge; no frame after release.

Source files
------------

// File: rtl/alarm_zone_ctrl_if.sv
// Sensor/keypad/status bundle for the alarm zone controller.
// Latency: n/a (wires only).
// Backpressure: none; all signals are free-running levels or strobes.
//
// master: drives sensors and keypad, observes siren and serial status.
// slave : the controller side.
interface alarm_zone_ctrl_if #(
    parameter int N_ZONES = 4,
    parameter int DIGIT_W = 2
);
    logic [N_ZONES-1:0] SENSOR_IN;
    logic [DIGIT_W-1:0] KB_IN;
    logic               KB_RECV;
    logic               SIREN_OUT;
    logic               STATUS_OUT;
    logic               STATUS_SEND;

    modport master (
        output SENSOR_IN, KB_IN, KB_RECV,
        input  SIREN_OUT, STATUS_OUT, STATUS_SEND
    );

    modport slave (
        input  SENSOR_IN, KB_IN, KB_RECV,
        output SIREN_OUT, STATUS_OUT, STATUS_SEND
    );
endinterface

// File: rtl/alarm_zone_ctrl.sv
// Alarm zone controller: keypad code arm/disarm, zone latch, siren, serial status frames.
// Latency: state change one clock after the causing input; status frame starts with the new state.
// Backpressure: none; state changes during a frame merge into one pending frame.
//
// Ports: SERCLK_OUT (clock, rising edge), RESET_IN (async, active low),
//        bus (alarm_zone_ctrl_if.slave): SENSOR_IN, KB_IN, KB_RECV in; SIREN_OUT, STATUS_OUT, STATUS_SEND out.
// Build option: define ALARM_ENTRY_DELAY_EN to add the ENTRY state with its entry-delay counter;
//               without it a trip while ARMED goes straight to ALARM.
module alarm_zone_ctrl #(
    parameter int N_ZONES      = 4,
    parameter int DIGIT_W      = 2,
    parameter int CODE_LEN     = 4,
    parameter logic [CODE_LEN*DIGIT_W-1:0] CODE = {CODE_LEN{DIGIT_W'(1)}},
    parameter int MAX_TRIES    = 3,
    parameter int ENTRY_CYCLES = 8
) (
    input logic              SERCLK_OUT,
    input logic              RESET_IN,
    alarm_zone_ctrl_if.slave bus
);
    localparam int BUF_W   = CODE_LEN * DIGIT_W;
    localparam int FRAME_W = 3 + N_ZONES;
    localparam int DCW     = $clog2(CODE_LEN + 1);
    localparam int WTW     = $clog2(MAX_TRIES + 1);
    localparam int FCW     = $clog2(FRAME_W + 1);

    localparam logic [DCW-1:0] DIG_LAST  = DCW'(CODE_LEN - 1);
    localparam logic [WTW-1:0] TRY_LAST  = WTW'(MAX_TRIES - 1);
    localparam logic [FCW-1:0] FRAME_LEN = FCW'(FRAME_W);
    localparam logic [FCW-1:0] FRAME_ONE = FCW'(1);

`ifdef ALARM_ENTRY_DELAY_EN
    localparam int EW = $clog2(ENTRY_CYCLES + 1);
    localparam logic [EW-1:0] ENTRY_LAST = EW'(ENTRY_CYCLES - 1);
    localparam logic [EW-1:0] ENTRY_FULL = EW'(ENTRY_CYCLES);
    typedef enum logic [1:0] {DISARMED = 2'b00, ARMED = 2'b01, ENTRY = 2'b10, ALARM = 2'b11} state_e;
`else
    typedef enum logic [1:0] {DISARMED = 2'b00, ARMED = 2'b01, ALARM = 2'b11} state_e;
`endif

    state_e             state_q, state_d;
    logic               kb_recv_q, kb_recv_d;
    logic [BUF_W-1:0]   dig_buf_q, dig_buf_d;
    logic [DCW-1:0]     dig_cnt_q, dig_cnt_d;
    logic [WTW-1:0]     wrong_cnt_q, wrong_cnt_d;
    logic [N_ZONES-1:0] zone_q, zone_d;
    logic               siren_q, siren_d;
    logic [FRAME_W-1:0] frame_sr_q, frame_sr_d;
    logic [FCW-1:0]     frame_cnt_q, frame_cnt_d;
    logic               pending_q, pending_d;
`ifdef ALARM_ENTRY_DELAY_EN
    logic [EW-1:0]      entry_cnt_q, entry_cnt_d;
`endif

    logic               kb_edge;
    logic               code_done;
    logic               code_ok;
    logic               state_change;
    logic [FRAME_W-1:0] frame_word;

    always_comb begin
        state_d      = state_q;
        kb_recv_d    = bus.KB_RECV;
        dig_buf_d    = dig_buf_q;
        dig_cnt_d    = dig_cnt_q;
        wrong_cnt_d  = wrong_cnt_q;
        zone_d       = zone_q;
        frame_sr_d   = frame_sr_q;
        frame_cnt_d  = frame_cnt_q;
        pending_d    = pending_q;
        code_done    = 1'b0;
        code_ok      = 1'b0;
`ifdef ALARM_ENTRY_DELAY_EN
        entry_cnt_d  = '0;
`endif

        // Keypad: one digit per rising edge of the strobe, newest digit in the LS position.
        kb_edge = bus.KB_RECV & ~kb_recv_q;
        if (kb_edge) begin
            dig_buf_d = BUF_W'({dig_buf_q, bus.KB_IN});
            if (dig_cnt_q == DIG_LAST) begin
                code_done = 1'b1;
                code_ok   = (dig_buf_d == CODE);
                dig_cnt_d = '0;
            end else begin
                dig_cnt_d = dig_cnt_q + 1'b1;
            end
        end

        // A completed code entry always wins over sensor trips and the entry timeout.
        if (code_done) begin
            if (code_ok) begin
                wrong_cnt_d = '0;
                if (state_q == DISARMED) begin
                    state_d = (|bus.SENSOR_IN) ? DISARMED : ARMED;
                end else begin
                    state_d = DISARMED;
                end
            end else if (wrong_cnt_q == TRY_LAST) begin
                wrong_cnt_d = '0;
                state_d     = ALARM;
            end else begin
                wrong_cnt_d = wrong_cnt_q + 1'b1;
            end
        end else begin
            case (state_q)
                ARMED: begin
                    if (|bus.SENSOR_IN) begin
`ifdef ALARM_ENTRY_DELAY_EN
                        state_d = ENTRY;
`else
                        state_d = ALARM;
`endif
                    end
                end
`ifdef ALARM_ENTRY_DELAY_EN
                ENTRY: begin
                    if (entry_cnt_q >= ENTRY_LAST) state_d = ALARM;
                end
`endif
                default: ;
            endcase
        end

`ifdef ALARM_ENTRY_DELAY_EN
        // Counts clocks spent in ENTRY; saturates so a late wrong code cannot wrap it.
        if (state_q == ENTRY && state_d == ENTRY) begin
            entry_cnt_d = (entry_cnt_q == ENTRY_FULL) ? entry_cnt_q : entry_cnt_q + 1'b1;
        end
`endif

        if (state_d == DISARMED) begin
            zone_d = '0;
        end else if (state_q != DISARMED) begin
            zone_d = zone_q | bus.SENSOR_IN;
        end

        siren_d = (state_d == ALARM);

        // Status framing: idle or last bit -> start a new frame if anything changed;
        // mid-frame changes only raise pending, sampled again at the last bit.
        state_change = (state_d != state_q);
        frame_word   = {1'b1, state_d, zone_d};
        if (frame_cnt_q <= FRAME_ONE) begin
            if (state_change || pending_q) begin
                frame_sr_d  = frame_word;
                frame_cnt_d = FRAME_LEN;
            end else begin
                frame_sr_d  = '0;
                frame_cnt_d = '0;
            end
            pending_d = 1'b0;
        end else begin
            frame_sr_d  = frame_sr_q << 1;
            frame_cnt_d = frame_cnt_q - 1'b1;
            pending_d   = pending_q | state_change;
        end
    end

    always_ff @(posedge SERCLK_OUT or negedge RESET_IN) begin
        if (!RESET_IN) begin
            state_q     <= DISARMED;
            kb_recv_q   <= 1'b0;
            dig_buf_q   <= '0;
            dig_cnt_q   <= '0;
            wrong_cnt_q <= '0;
            zone_q      <= '0;
            siren_q     <= 1'b0;
            frame_sr_q  <= '0;
            frame_cnt_q <= '0;
            pending_q   <= 1'b0;
`ifdef ALARM_ENTRY_DELAY_EN
            entry_cnt_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            kb_recv_q   <= kb_recv_d;
            dig_buf_q   <= dig_buf_d;
            dig_cnt_q   <= dig_cnt_d;
            wrong_cnt_q <= wrong_cnt_d;
            zone_q      <= zone_d;
            siren_q     <= siren_d;
            frame_sr_q  <= frame_sr_d;
            frame_cnt_q <= frame_cnt_d;
            pending_q   <= pending_d;
`ifdef ALARM_ENTRY_DELAY_EN
            entry_cnt_q <= entry_cnt_d;
`endif
        end
    end

    assign bus.SIREN_OUT   = siren_q;
    assign bus.STATUS_SEND = (frame_cnt_q != '0);
    assign bus.STATUS_OUT  = frame_sr_q[FRAME_W-1] & bus.STATUS_SEND;

endmodule

// File: tb/tb_alarm_zone_ctrl.sv
// Bench for alarm_zone_ctrl: directed scenarios followed by random keypad/sensor traffic,
// every cycle checked against a queue-based behavioural model of states and status frames.
module tb_alarm_zone_ctrl;
    localparam int NZ = 4;
    localparam int DW = 2;
    localparam int CL = 4;
    localparam int MT = 3;
    localparam int EC = 8;
`ifdef ALARM_ENTRY_DELAY_EN
    localparam bit ENTRY_EN = 1'b1;
`else
    localparam bit ENTRY_EN = 1'b0;
`endif
    localparam int S_DIS = 0, S_ARM = 1, S_ENT = 2, S_ALM = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alarm_zone_ctrl_if #(.N_ZONES(NZ), .DIGIT_W(DW)) bus ();

    alarm_zone_ctrl #(
        .N_ZONES(NZ), .DIGIT_W(DW), .CODE_LEN(CL), .MAX_TRIES(MT), .ENTRY_CYCLES(EC)
    ) dut (
        .SERCLK_OUT(clk),
        .RESET_IN  (rst_n),
        .bus       (bus)
    );

    int vectors = 0;
    int miscompares = 0;

    // Behavioural model state
    int        m_state;
    int        m_wrong;
    int        m_entry_t;
    logic [3:0] m_zone;
    int        m_digits[$];
    bit        m_bits[$];
    bit        m_kb_prev;
    bit        m_pending;
    logic      exp_siren, exp_send, exp_out;

    logic [6:0] obs;
    int         obs_n;

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        vectors++;
        assert (o === e) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, e);
        end
    endtask

    task automatic model_reset();
        m_state = S_DIS; m_wrong = 0; m_entry_t = 0; m_zone = '0;
        m_digits.delete(); m_bits.delete();
        m_kb_prev = 1'b0; m_pending = 1'b0;
        exp_siren = 1'b0; exp_send = 1'b0; exp_out = 1'b0;
    endtask

    // Called just after a rising edge: applies the spec rules to the inputs that edge sampled.
    task automatic model_edge();
        int  nxt;
        bit  done, ok, changed;
        if (!rst_n) begin
            model_reset();
            return;
        end
        nxt = m_state; done = 0; ok = 0;
        if (bus.KB_RECV && !m_kb_prev) begin
            m_digits.push_back(int'(bus.KB_IN));
            if (m_digits.size() == CL) begin
                done = 1; ok = 1;
                foreach (m_digits[i]) if (m_digits[i] != 1) ok = 0;
                m_digits.delete();
            end
        end
        m_kb_prev = bus.KB_RECV;
        if (m_state == S_ENT) m_entry_t++;

        if (done) begin
            if (ok) begin
                m_wrong = 0;
                if (m_state == S_DIS) nxt = (bus.SENSOR_IN == 0) ? S_ARM : S_DIS;
                else nxt = S_DIS;
            end else begin
                m_wrong++;
                if (m_wrong == MT) begin m_wrong = 0; nxt = S_ALM; end
            end
        end else if (m_state == S_ARM && bus.SENSOR_IN != 0) begin
            nxt = ENTRY_EN ? S_ENT : S_ALM;
        end else if (m_state == S_ENT && m_entry_t >= EC) begin
            nxt = S_ALM;
        end
        if (nxt == S_ENT && m_state != S_ENT) m_entry_t = 0;

        if (nxt == S_DIS) m_zone = '0;
        else if (m_state != S_DIS) m_zone = m_zone | bus.SENSOR_IN;

        changed = (nxt != m_state);
        m_state = nxt;
        if (m_bits.size() == 0) begin
            if (changed || m_pending) begin
                m_bits.push_back(1'b1);
                m_bits.push_back(m_state[1]);
                m_bits.push_back(m_state[0]);
                for (int z = NZ - 1; z >= 0; z--) m_bits.push_back(m_zone[z]);
                m_pending = 1'b0;
            end
        end else begin
            m_pending = m_pending | changed;
        end
        if (m_bits.size() > 0) begin
            exp_send = 1'b1;
            exp_out  = m_bits.pop_front();
        end else begin
            exp_send = 1'b0;
            exp_out  = 1'b0;
        end
        exp_siren = (m_state == S_ALM);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("siren", bus.SIREN_OUT, exp_siren);
        chk("send", bus.STATUS_SEND, exp_send);
        chk("out", bus.STATUS_OUT, exp_out);
        if (bus.STATUS_SEND) begin
            obs = {obs[5:0], bus.STATUS_OUT};
            obs_n++;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic enter_digit(input int d, input int hold);
        bus.KB_IN = DW'(d);
        bus.KB_RECV = 1'b1;
        repeat (hold) step();
        bus.KB_RECV = 1'b0;
        step();
    endtask

    task automatic enter_code(input int d, input int first_hold);
        enter_digit(d, first_hold);
        repeat (CL - 1) enter_digit(d, 1);
    endtask

    task automatic clr_obs();
        obs = '0;
        obs_n = 0;
    endtask

    initial begin
        bus.SENSOR_IN = '0;
        bus.KB_IN = '0;
        bus.KB_RECV = 1'b0;
        model_reset();
        clr_obs();

        // Reset state, then quiet after release
        idle(3);
        rst_n = 1'b1;
        idle(5);
        chk("no_frame_after_reset", obs_n, 0);

        // Arm with correct code
        clr_obs();
        enter_code(1, 1);
        idle(10);
        chk("arm_frame", obs, 7'b1010000);
        chk("arm_len", obs_n, 7);

        // Trip zone 1 while armed
        clr_obs();
        bus.SENSOR_IN = 4'b0010;
        step();
        bus.SENSOR_IN = '0;
        idle(22);
        chk("trip_siren", bus.SIREN_OUT, 1);
        chk("trip_frame", obs, 7'b1110010);
        chk("trip_len", obs_n, ENTRY_EN ? 14 : 7);

        // Disarm from alarm
        clr_obs();
        enter_code(1, 1);
        idle(10);
        chk("disarm_frame", obs, 7'b1000000);
        chk("disarm_siren", bus.SIREN_OUT, 0);

`ifdef ALARM_ENTRY_DELAY_EN
        // Disarm inside the entry window: three digits pre-entered, last one after the trip
        enter_code(1, 1);
        idle(10);
        clr_obs();
        repeat (CL - 1) enter_digit(1, 1);
        bus.SENSOR_IN = 4'b0010;
        step();
        bus.SENSOR_IN = '0;
        enter_digit(1, 1);
        repeat (12) begin
            step();
            chk("entry_siren", bus.SIREN_OUT, 0);
        end
        chk("entry_disarm_frame", obs, 7'b1000000);
        chk("entry_disarm_len", obs_n, 14);
`endif

        // Three wrong codes, first digit held for five cycles
        clr_obs();
        enter_code(0, 5);
        enter_code(0, 1);
        chk("two_wrong_no_frame", obs_n, 0);
        enter_code(0, 1);
        chk("wrong_siren", bus.SIREN_OUT, 1);

        // Asynchronous reset in the middle of the alarm frame
        chk("mid_frame_send", bus.STATUS_SEND, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_siren", bus.SIREN_OUT, 0);
        chk("rst_send", bus.STATUS_SEND, 0);
        chk("rst_out", bus.STATUS_OUT, 0);
        model_reset();
        idle(2);
        rst_n = 1'b1;
        clr_obs();
        idle(10);
        chk("no_frame_after_rst", obs_n, 0);

        // Arm refused with a zone open
        bus.SENSOR_IN = 4'b0001;
        enter_code(1, 1);
        idle(5);
        bus.SENSOR_IN = '0;
        idle(2);
        chk("arm_refused_no_frame", obs_n, 0);
        chk("arm_refused_siren", bus.SIREN_OUT, 0);

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 55) begin
                enter_digit(($urandom_range(0, 3) != 0) ? 1 : $urandom_range(0, 3), $urandom_range(1, 3));
            end else if (r < 75) begin
                bus.SENSOR_IN = 4'(1 << $urandom_range(0, NZ - 1));
                repeat ($urandom_range(1, 2)) step();
                bus.SENSOR_IN = '0;
            end else if (r < 98) begin
                idle($urandom_range(1, 9));
            end else begin
                rst_n = 1'b0;
                idle(2);
                rst_n = 1'b1;
            end
        end
        idle(20);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
